param_data_path: RTL
====================

PARAM_DATA_PATH -- requirements
Module: param_data_path

Interface
REQ-001 SHALL have parameter: DATA_W, 16, datapath/register/memory-data width (>=16).
REQ-002 SHALL have parameter: ADDR_W, 5, PC and RAM address width (1..8).
REQ-003 SHALL have parameter: REG_AW, 2, register-index width (1..2); register count = 2**REG_AW.
REQ-004 SHALL have ports, one per line: name, direction, width, meaning:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-high (rst_n=1 resets).
- branch  in  1  PC load select: 1 = load mem_addr, 0 = increment.
- pc_enable  in  1  PC update enable.
- ir_enable  in  1  IR load enable.
- addr_sel  in  1  ram_addr select: 1 = mem_addr, 0 = PC.
- c_sel  in  1  write-back select: 1 = data_in, 0 = ALU result.
- operation  in  3  ALU op code.
- write_reg_enable  in  1  register-file write enable.
- flags_reg_enable  in  1  flag register update enable.
- opcode  out  5  IR[15:11].
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
- ram_addr  out  ADDR_W  memory address.
- data_out  out  DATA_W  store data.
- data_in  in  DATA_W  memory read data.

Function
REQ-005 SHALL load IR <= data_in[15:0] on clk edge when ir_enable=1; hold otherwise.
REQ-006 SHALL decode IR fields: c = IR[10:9], a = IR[8:7], b = IR[6:5] (low REG_AW bits used), mem_addr = IR[ADDR_W-1:0]; fields may overlap.
REQ-007 SHALL, when pc_enable=1, set PC <= mem_addr if branch=1, else PC+1 modulo 2**ADDR_W (31 -> 0 at ADDR_W=5); hold when pc_enable=0.
REQ-008 SHALL drive ram_addr combinationally = addr_sel ? mem_addr : PC.
REQ-009 SHALL read bus_a = reg[a], bus_b = reg[b] combinationally; data_out = bus_a.
REQ-010 SHALL compute the ALU result combinationally at DATA_W bits: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 PASS_A, 110/111 result 0.
REQ-011 SHALL compute ADD overflow: unsigned = carry out of MSB; signed = (a_msb==b_msb) && (res_msb!=a_msb).
REQ-012 SHALL compute SUB as a+~b+1; unsigned overflow = borrow (a<b unsigned); signed = (a_msb!=b_msb) && (res_msb!=a_msb).
REQ-013 SHALL force both overflow terms to 0 for ops 010-111.
REQ-014 SHALL, when write_reg_enable=1, write reg[c] <= c_sel ? data_in : ALU result at clk edge.
REQ-015 SHALL return the pre-write value on a same-cycle read of the written register (no bypass).
REQ-016 SHALL, when flags_reg_enable=1, register zero = (result==0), neg = result MSB, unsigned/signed overflow per REQ-011..013; hold otherwise.
REQ-017 SHALL drive flag outputs only from the flag register, never combinationally.
REQ-018 SHALL allow pc_enable, ir_enable, write_reg_enable and flags_reg_enable simultaneously; each update uses pre-edge values.

Reset
REQ-019 SHALL clear PC, IR, all registers and all four flags to 0 on a clk edge with rst_n=1.
REQ-020 SHALL give reset priority over every enable; opcode=0, ram_addr=0, data_out=0 in the cycle after reset.
REQ-021 SHALL take effect identically when asserted mid-operation (any enable active).

Verification
REQ-022 Reset mid-op: pc_enable=1, write_reg_enable=1, rst_n=1 for one edge -> PC=0, all registers 0, flags 0, ram_addr=0.
REQ-023 Load: IR<=0x0600 (c=3), c_sel=1, write_reg_enable=1, data_in=0xBEEF -> reg3=0xBEEF; IR<=0x0180 (a=3) -> data_out=0xBEEF.
REQ-024 ADD, DATA_W=16: regs 0x7FFF + 0x0001, flags_reg_enable=1 -> result 0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
REQ-025 SUB: 0x0000 - 0x0001 -> 0xFFFF, unsigned_overflow=1, signed_overflow=0, neg=1; then ADD 0xFFFF+0x0001 -> zero=1, unsigned_overflow=1.
REQ-026 PC, ADDR_W=5: PC=31, pc_enable=1, branch=0 -> PC=0; IR low bits 0x0A, branch=1 -> PC=10, ram_addr=10 with addr_sel=0.
REQ-027 Hold: flags_reg_enable=0 while ALU result changes -> all flags unchanged.

Source files
------------

// File: rtl/param_data_path.sv
// param_data_path
// Single-cycle style datapath: program counter, 16-bit instruction register,
// small register file, ALU with zero/negative/overflow flags, and memory
// address / store-data generation for an external RAM.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst_n             synchronous reset, active HIGH despite the name
//   branch            PC load select: 1 = mem_addr, 0 = PC+1
//   pc_enable         PC update enable
//   ir_enable         IR load enable (loads data_in[15:0])
//   addr_sel          ram_addr select: 1 = mem_addr, 0 = PC
//   c_sel             write-back select: 1 = data_in, 0 = ALU result
//   operation         ALU op code
//   write_reg_enable  register-file write enable (destination = c field)
//   flags_reg_enable  flag register update enable
//   opcode            IR[15:11]
//   zero_op, neg_op, unsigned_overflow, signed_overflow  registered flags
//   ram_addr          memory address
//   data_out          store data (register selected by the a field)
//   data_in           memory read data
module param_data_path #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch,
  input  logic              pc_enable,
  input  logic              ir_enable,
  input  logic              addr_sel,
  input  logic              c_sel,
  input  logic [2:0]        operation,
  input  logic              write_reg_enable,
  input  logic              flags_reg_enable,
  output logic [4:0]        opcode,
  output logic              zero_op,
  output logic              neg_op,
  output logic              unsigned_overflow,
  output logic              signed_overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);

  localparam int NREG = 2 ** REG_AW;

  logic [15:0]        ir_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic               zero_reg, neg_reg, uov_reg, sov_reg;

  // Instruction fields; only the low REG_AW bits of each 2-bit field are used
  // and the fields are allowed to overlap each other and mem_addr.
  logic [REG_AW-1:0]  c_idx, a_idx, b_idx;
  logic [ADDR_W-1:0]  mem_addr;

  assign c_idx    = ir_reg[9 +: REG_AW];
  assign a_idx    = ir_reg[7 +: REG_AW];
  assign b_idx    = ir_reg[5 +: REG_AW];
  assign mem_addr = ir_reg[ADDR_W-1:0];
  assign opcode   = ir_reg[15:11];

  // ---------------------------------------------------------------- IR / PC
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ir_reg <= '0;
    end else if (ir_enable) begin
      ir_reg <= data_in[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_reg <= '0;
    end else if (pc_enable) begin
      pc_reg <= branch ? mem_addr : pc_reg + ADDR_W'(1);
    end
  end

  assign ram_addr = addr_sel ? mem_addr : pc_reg;

  // ---------------------------------------------------------- register file
  // Each register lives in its own generate block so the whole file can be
  // cleared on reset. Reads are combinational from the current contents, so
  // a read of the register being written returns the old value.
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] bus_a, bus_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] wb_data;

  assign wb_data = c_sel ? data_in : alu_res;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
      if (rst_n) begin
        q_reg <= '0;
      end else if (write_reg_enable && (c_idx == REG_AW'(gi))) begin
        q_reg <= wb_data;
      end
    end

    assign rf[gi] = q_reg;
  end

  assign bus_a    = rf[a_idx];
  assign bus_b    = rf[b_idx];
  assign data_out = bus_a;

  // -------------------------------------------------------------------- ALU
  // One extra bit on the adders captures carry out; for subtraction a set
  // carry means "no borrow", so unsigned overflow is its inverse.
  logic [DATA_W:0] sum_ext, diff_ext;
  logic            uov_next, sov_next;

  assign sum_ext  = {1'b0, bus_a} + {1'b0, bus_b};
  assign diff_ext = {1'b0, bus_a} + {1'b0, ~bus_b} + (DATA_W+1)'(1);

  always_comb begin
    alu_res  = '0;
    uov_next = 1'b0;
    sov_next = 1'b0;
    case (operation)
      3'b000: begin
        alu_res  = sum_ext[DATA_W-1:0];
        uov_next = sum_ext[DATA_W];
        sov_next = (bus_a[DATA_W-1] == bus_b[DATA_W-1]) &&
                   (sum_ext[DATA_W-1] != bus_a[DATA_W-1]);
      end
      3'b001: begin
        alu_res  = diff_ext[DATA_W-1:0];
        uov_next = ~diff_ext[DATA_W];
        sov_next = (bus_a[DATA_W-1] != bus_b[DATA_W-1]) &&
                   (diff_ext[DATA_W-1] != bus_a[DATA_W-1]);
      end
      3'b010:  alu_res = bus_a & bus_b;
      3'b011:  alu_res = bus_a | bus_b;
      3'b100:  alu_res = bus_a ^ bus_b;
      3'b101:  alu_res = bus_a;
      default: alu_res = '0;
    endcase
  end

  // ------------------------------------------------------------------ flags
  always_ff @(posedge clk) begin
    if (rst_n) begin
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
      uov_reg  <= 1'b0;
      sov_reg  <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_reg <= (alu_res == '0);
      neg_reg  <= alu_res[DATA_W-1];
      uov_reg  <= uov_next;
      sov_reg  <= sov_next;
    end
  end

  assign zero_op           = zero_reg;
  assign neg_op            = neg_reg;
  assign unsigned_overflow = uov_reg;
  assign signed_overflow   = sov_reg;

endmodule
